lshift_deser: RTL and testbench
===============================

LSHIFT_DESER -- requirements
Module: lshift_deser

Interface
REQ-001 Parameter WIDTH, default 8: serial word length in bits; the block SHALL support values 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 means the first received bit is the word MSB; 0 means the first received bit is the LSB.
REQ-003 clk  input  1  single clock; all state SHALL update on its rising edge only.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 sin  input  1  serial data bit, sampled only when sin_en=1.
REQ-006 sin_en  input  1  bit-valid strobe: one bit is consumed per clk edge with sin_en=1.
REQ-007 frame_clr  input  1  discards the partially received word.
REQ-008 data_ready  input  1  downstream accept signal.
REQ-009 overrun_clr  input  1  clears the sticky overrun flag.
REQ-010 data_out  output  WIDTH  completed parallel word, registered.
REQ-011 data_valid  output  1  data_out holds an unaccepted word, registered.
REQ-012 busy  output  1  high while a partial word is held (bit count != 0).
REQ-013 overrun  output  1  sticky: a completed word was dropped.

Function
REQ-014 Internal state SHALL be: shift register sr[WIDTH-1:0] and bit counter cnt (0..WIDTH-1), with implied states IDLE (cnt=0) and RECV (cnt>0).
REQ-015 On an edge with sin_en=1 and MSB_FIRST=1: sr <= {sr[WIDTH-2:0], sin}.
REQ-016 On an edge with sin_en=1 and MSB_FIRST=0: sr <= {sin, sr[WIDTH-1:1]}.
REQ-017 On an edge with sin_en=1: cnt SHALL increment, wrapping from WIDTH-1 to 0.
REQ-018 On an edge with sin_en=0: sr and cnt SHALL hold.
REQ-019 Word completion: the edge that samples the bit with cnt=WIDTH-1 completes the word; the completed value is the post-shift sr.
REQ-020 Completion latency: the completed word SHALL appear on data_out with data_valid=1 immediately after the completing edge, i.e. zero extra cycles.
REQ-021 Handshake: a word is accepted on an edge with data_valid=1 and data_ready=1; data_valid SHALL then fall unless a new word completes on the same edge.
REQ-022 Accept and completion on the same edge: data_out SHALL load the new word, data_valid SHALL stay 1, and overrun SHALL NOT set.
REQ-023 Completion while data_valid=1 and data_ready=0: the new word is discarded, data_out and data_valid SHALL hold, and overrun SHALL set to 1.
REQ-024 data_out SHALL NOT change while data_valid=1 and data_ready=0.
REQ-025 frame_clr=1: sr <= 0 and cnt <= 0; frame_clr has priority over sin_en on the same edge, so the bit is discarded and no completion occurs.
REQ-026 frame_clr SHALL NOT affect data_out, data_valid or overrun.
REQ-027 overrun_clr=1 SHALL clear overrun; if an overrun event occurs on the same edge, set wins and overrun stays 1.
REQ-028 busy SHALL be combinational from cnt: busy = (cnt != 0).
REQ-029 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-030 When rst=1 at a clk edge: sr=0, cnt=0, data_out=0, data_valid=0, overrun=0, busy=0.
REQ-031 rst SHALL have priority over all other inputs, including mid-word; the partial word is lost and reception restarts from bit 0.

Verification
REQ-032 Scenario 1 (WIDTH=8, MSB_FIRST=1, data_ready=1): bits 1,1,0,1,0,0,0,0 on consecutive edges -> data_out=8'hD0, data_valid=1 for one cycle after the 8th edge, busy=0.
REQ-033 Scenario 2 (MSB_FIRST=0): same bit sequence -> data_out=8'h0B.
REQ-034 Scenario 3: sin_en toggled 1/0 every cycle while sending 8'h3C MSB-first -> same 8'h3C result after 16 edges; busy=1 from the 1st to the 7th bit.
REQ-035 Scenario 4: data_ready=0; send 8'hD0 then 8'h3C -> data_out stays 8'hD0 and overrun=1; then data_ready=1 for one edge -> data_valid=0; then overrun_clr pulse -> overrun=0.
REQ-036 Scenario 5: data_ready=1 exactly on the completing edge of a second word -> data_out changes from the first word to the second and data_valid stays 1 with no gap; overrun=0.
REQ-037 Scenario 6a: 3 bits sent, then frame_clr together with sin_en=1, then 8 bits of 8'h5A -> data_out=8'h5A.
REQ-038 Scenario 6b: rst asserted after 5 bits -> all outputs 0; then a full 8'hA5 -> data_out=8'hA5.

Source files
------------

// File: rtl/lshift_deser.sv
// Serial-to-parallel deserializer: shifts in WIDTH bits per word, MSB- or LSB-first,
// and presents each completed word on a registered valid/ready output with sticky overrun.
module lshift_deser #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    input  logic             frame_clr,
    input  logic             data_ready,
    input  logic             overrun_clr,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_next;
    logic [CW-1:0]    cnt;
    logic             complete;
    logic             accept;
    logic             load;

    // Output handshake: a word transfers on any edge where data_valid and data_ready
    // are both high. data_out is frozen while data_valid=1 and data_ready=0; a word
    // completing in that window is dropped and raises the sticky overrun flag.
    always_comb begin
        sr_next = MSB_FIRST ? {sr[WIDTH-2:0], sin} : {sin, sr[WIDTH-1:1]};
    end

    assign complete = sin_en && !frame_clr && (cnt == LAST);
    assign accept   = data_valid && data_ready;
    assign load     = complete && (!data_valid || data_ready);
    // busy doubles as the IDLE/RECV state indicator of the bit counter.
    assign busy     = (cnt != '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            sr         <= '0;
            cnt        <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (frame_clr) begin
                sr  <= '0;
                cnt <= '0;
            end else if (sin_en) begin
                sr  <= sr_next;
                cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
            end

            if (load) begin
                data_out   <= sr_next;
                data_valid <= 1'b1;
            end else if (accept) begin
                data_valid <= 1'b0;
            end

            // Set beats clear when both happen on the same edge.
            if (complete && data_valid && !data_ready) begin
                overrun <= 1'b1;
            end else if (overrun_clr) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lshift_deser.sv
// Directed bench for lshift_deser: one MSB-first and one LSB-first instance share stimulus;
// each scenario task checks hand-computed expectations inline.
module tb_lshift_deser;

    logic       clk = 1'b0;
    logic       rst, sin, sin_en, frame_clr, data_ready, overrun_clr;
    logic [7:0] m_out, l_out;
    logic       m_valid, l_valid, m_busy, l_busy, m_ovr, l_ovr;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    lshift_deser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .frame_clr(frame_clr),
        .data_ready(data_ready), .overrun_clr(overrun_clr),
        .data_out(m_out), .data_valid(m_valid), .busy(m_busy), .overrun(m_ovr)
    );

    lshift_deser #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(sin_en), .frame_clr(frame_clr),
        .data_ready(data_ready), .overrun_clr(overrun_clr),
        .data_out(l_out), .data_valid(l_valid), .busy(l_busy), .overrun(l_ovr)
    );

    // Advance one rising edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        sin    = b;
        sin_en = 1'b1;
        tick();
        sin_en = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w);
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_cmp++; if ({m_out, m_valid, m_busy, m_ovr} !== 11'h0) begin
            n_bad++; $display("FAIL reset_m got=%h exp=000", {m_out, m_valid, m_busy, m_ovr}); end
        n_cmp++; if ({l_out, l_valid, l_busy, l_ovr} !== 11'h0) begin
            n_bad++; $display("FAIL reset_l got=%h exp=000", {l_out, l_valid, l_busy, l_ovr}); end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [7:0] w;
        w = 8'hD0;
        data_ready = 1'b1;
        send_bit(w[7]);
        n_cmp++; if (m_busy !== 1'b1) begin
            n_bad++; $display("FAIL basic_busy_first got=%b exp=1", m_busy); end
        for (int i = 6; i >= 0; i--) send_bit(w[i]);
        n_cmp++; if (m_out !== 8'hD0 || m_valid !== 1'b1) begin
            n_bad++; $display("FAIL basic_msb got=%h/%b exp=d0/1", m_out, m_valid); end
        n_cmp++; if (l_out !== 8'h0B || l_valid !== 1'b1) begin
            n_bad++; $display("FAIL basic_lsb got=%h/%b exp=0b/1", l_out, l_valid); end
        n_cmp++; if (m_busy !== 1'b0) begin
            n_bad++; $display("FAIL basic_busy_done got=%b exp=0", m_busy); end
        tick();
        n_cmp++; if (m_valid !== 1'b0 || m_out !== 8'hD0) begin
            n_bad++; $display("FAIL basic_accept got=%h/%b exp=d0/0", m_out, m_valid); end
    endtask

    task automatic test_gapped();
        logic [7:0] w;
        w = 8'h3C;
        data_ready = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0) begin
                n_cmp++; if (m_busy !== 1'b1) begin
                    n_bad++; $display("FAIL gap_busy bit=%0d got=%b exp=1", 7 - i, m_busy); end
            end else begin
                n_cmp++; if (m_out !== 8'h3C || m_valid !== 1'b1 || m_busy !== 1'b0) begin
                    n_bad++; $display("FAIL gap_word got=%h/%b/%b exp=3c/1/0", m_out, m_valid, m_busy); end
            end
            tick();
        end
        n_cmp++; if (m_out !== 8'h3C || m_valid !== 1'b0) begin
            n_bad++; $display("FAIL gap_after got=%h/%b exp=3c/0", m_out, m_valid); end
    endtask

    task automatic test_overrun();
        data_ready = 1'b0;
        send_word(8'hD0);
        n_cmp++; if (m_out !== 8'hD0 || m_valid !== 1'b1 || m_ovr !== 1'b0) begin
            n_bad++; $display("FAIL ovr_first got=%h/%b/%b exp=d0/1/0", m_out, m_valid, m_ovr); end
        send_word(8'h3C);
        n_cmp++; if (m_out !== 8'hD0 || m_valid !== 1'b1 || m_ovr !== 1'b1) begin
            n_bad++; $display("FAIL ovr_drop got=%h/%b/%b exp=d0/1/1", m_out, m_valid, m_ovr); end
        // clear and a fresh overrun on the same edge: set must win
        overrun_clr = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (i == 0) overrun_clr = 1'b1;
            send_bit(1'b1);
        end
        overrun_clr = 1'b0;
        n_cmp++; if (m_ovr !== 1'b1 || m_out !== 8'hD0) begin
            n_bad++; $display("FAIL ovr_set_wins got=%h/%b exp=d0/1", m_out, m_ovr); end
        data_ready = 1'b1;
        tick();
        data_ready = 1'b0;
        n_cmp++; if (m_valid !== 1'b0 || m_ovr !== 1'b1) begin
            n_bad++; $display("FAIL ovr_accept got=%b/%b exp=0/1", m_valid, m_ovr); end
        overrun_clr = 1'b1;
        tick();
        overrun_clr = 1'b0;
        n_cmp++; if (m_ovr !== 1'b0 || l_ovr !== 1'b0) begin
            n_bad++; $display("FAIL ovr_clear got=%b/%b exp=0/0", m_ovr, l_ovr); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] w;
        w = 8'h3C;
        data_ready = 1'b0;
        send_word(8'hD0);
        for (int i = 7; i >= 0; i--) begin
            data_ready = (i == 0);
            send_bit(w[i]);
            if (i != 0) begin
                n_cmp++; if (m_out !== 8'hD0 || m_valid !== 1'b1) begin
                    n_bad++; $display("FAIL b2b_hold bit=%0d got=%h/%b exp=d0/1", 7 - i, m_out, m_valid); end
            end
        end
        n_cmp++; if (m_out !== 8'h3C || m_valid !== 1'b1 || m_ovr !== 1'b0) begin
            n_bad++; $display("FAIL b2b_swap got=%h/%b/%b exp=3c/1/0", m_out, m_valid, m_ovr); end
        data_ready = 1'b1;
        tick();
        n_cmp++; if (m_valid !== 1'b0) begin
            n_bad++; $display("FAIL b2b_drain got=%b exp=0", m_valid); end
    endtask

    task automatic test_frame_clr();
        data_ready = 1'b1;
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        frame_clr = 1'b1;
        send_bit(1'b1);
        frame_clr = 1'b0;
        n_cmp++; if (m_busy !== 1'b0 || m_valid !== 1'b0) begin
            n_bad++; $display("FAIL fclr_idle got=%b/%b exp=0/0", m_busy, m_valid); end
        data_ready = 1'b0;
        send_word(8'h5A);
        n_cmp++; if (m_out !== 8'h5A || m_valid !== 1'b1 || l_out !== 8'h5A) begin
            n_bad++; $display("FAIL fclr_word got=%h/%b/%h exp=5a/1/5a", m_out, m_valid, l_out); end
        frame_clr = 1'b1;
        tick();
        frame_clr = 1'b0;
        n_cmp++; if (m_out !== 8'h5A || m_valid !== 1'b1 || m_ovr !== 1'b0) begin
            n_bad++; $display("FAIL fclr_outputs got=%h/%b/%b exp=5a/1/0", m_out, m_valid, m_ovr); end
        data_ready = 1'b1;
        tick();
    endtask

    task automatic test_mid_reset();
        data_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if ({m_out, m_valid, m_busy, m_ovr} !== 11'h0) begin
            n_bad++; $display("FAIL mrst_clear got=%h exp=000", {m_out, m_valid, m_busy, m_ovr}); end
        send_word(8'hA5);
        n_cmp++; if (m_out !== 8'hA5 || m_valid !== 1'b1 || l_out !== 8'hA5) begin
            n_bad++; $display("FAIL mrst_word got=%h/%b/%h exp=a5/1/a5", m_out, m_valid, l_out); end
    endtask

    initial begin
        rst = 1'b1; sin = 1'b0; sin_en = 1'b0; frame_clr = 1'b0;
        data_ready = 1'b0; overrun_clr = 1'b0;
        test_reset();
        test_basic();
        test_gapped();
        test_overrun();
        test_back_to_back();
        test_frame_clr();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
